// File: rtl/regfile_write_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile_write_ctrl_if                                         |
// | Brief    : Instruction handshake and register-file control bundle.       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface regfile_write_ctrl_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16
);
  logic                instr_valid;
  logic [15:0]         instr;
  logic                instr_ready;
  logic                busy;
  logic [3:0]          srcA_sel;
  logic [3:0]          srcB_sel;
  logic                imm_sel;
  logic [DATA_W-1:0]   imm;
  logic [7:0]          alu_op;
  logic [NUM_REGS-1:0] regEn;
  logic                flags_en;
  logic                done;

  modport master (
    output instr_valid, instr,
    input  instr_ready, busy, srcA_sel, srcB_sel, imm_sel, imm, alu_op,
           regEn, flags_en, done
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, busy, srcA_sel, srcB_sel, imm_sel, imm, alu_op,
           regEn, flags_en, done
  );
endinterface
`default_nettype wire

// File: rtl/regfile_write_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile_write_ctrl                                            |
// | Brief    : CR16 instruction sequencer driving register-file selects and  |
// |            the one-hot write enable. Option: REGFILE_WRITE_CTRL_R0_PROTECT_EN |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module regfile_write_ctrl #(
  parameter int DATA_W      = 16,
  parameter int NUM_REGS    = 16,
  parameter int EXEC_CYCLES = 1
) (
  input  wire logic           clk,
  input  wire logic           reset,
  regfile_write_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DECODE    = 2'd1,
    S_EXECUTE   = 2'd2,
    S_WRITEBACK = 2'd3
  } state_t;

  localparam logic [3:0]          c_cnt_load = 4'(EXEC_CYCLES - 1);
  localparam logic [NUM_REGS-1:0] c_one      = {{(NUM_REGS-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next_state;
  logic [15:0]         r_instr;
  logic [3:0]          r_cnt;
  logic [3:0]          r_srcA_sel;
  logic [3:0]          r_srcB_sel;
  logic                r_imm_sel;
  logic [DATA_W-1:0]   r_imm;
  logic [7:0]          r_alu_op;
  logic [NUM_REGS-1:0] r_regEn;
  logic                r_flags_en;
  logic                r_done;
  logic                w_accept;
  logic                w_is_cmp;
  logic                w_is_nop;
  logic [NUM_REGS-1:0] w_wr_mask;

  assign w_accept = (r_state == S_IDLE) && bus.instr_valid;

  // Class decode works on the latched copy so bus changes while busy are ignored
  assign w_is_nop = (r_instr == 16'h0000);
  assign w_is_cmp = ((r_instr[15:12] == 4'h0) && (r_instr[7:4] == 4'hB)) ||
                    (r_instr[15:12] == 4'hB);

  always_comb begin
    w_wr_mask = '0;
    if (!w_is_cmp && !w_is_nop) begin
      w_wr_mask = c_one << r_instr[11:8];
    end
`ifdef REGFILE_WRITE_CTRL_R0_PROTECT_EN
    if (r_instr[11:8] == 4'd0) begin
      w_wr_mask = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (w_accept) w_next_state = S_DECODE;
      S_DECODE:    w_next_state = S_EXECUTE;
      S_EXECUTE:   if (r_cnt == 4'd0) w_next_state = S_WRITEBACK;
      S_WRITEBACK: w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Selects are registered at the accept edge so they are already valid in DECODE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr    <= '0;
      r_cnt      <= '0;
      r_srcA_sel <= '0;
      r_srcB_sel <= '0;
      r_imm_sel  <= 1'b0;
      r_imm      <= '0;
      r_alu_op   <= '0;
      r_regEn    <= '0;
      r_flags_en <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_regEn    <= '0;
      r_flags_en <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_instr    <= bus.instr;
            r_srcA_sel <= bus.instr[11:8];
            r_srcB_sel <= bus.instr[3:0];
            r_imm_sel  <= (bus.instr[15:12] != 4'h0);
            r_imm      <= {{(DATA_W-8){bus.instr[7]}}, bus.instr[7:0]};
            r_alu_op   <= {bus.instr[15:12], bus.instr[7:4]};
          end
        end
        S_DECODE: begin
          r_cnt <= c_cnt_load;
        end
        S_EXECUTE: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_done     <= 1'b1;
            r_flags_en <= !w_is_nop;
            r_regEn    <= w_wr_mask;
          end
        end
        S_WRITEBACK: begin
          r_srcA_sel <= '0;
          r_srcB_sel <= '0;
          r_imm_sel  <= 1'b0;
          r_imm      <= '0;
          r_alu_op   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.instr_ready = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.srcA_sel    = r_srcA_sel;
  assign bus.srcB_sel    = r_srcB_sel;
  assign bus.imm_sel     = r_imm_sel;
  assign bus.imm         = r_imm;
  assign bus.alu_op      = r_alu_op;
  assign bus.regEn       = r_regEn;
  assign bus.flags_en    = r_flags_en;
  assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_regfile_write_ctrl                                         |
// | Brief    : Directed self-checking bench, EXEC_CYCLES=1 and =4 instances. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_regfile_write_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  regfile_write_ctrl_if #(.DATA_W(16), .NUM_REGS(16)) bus1 ();
  regfile_write_ctrl_if #(.DATA_W(16), .NUM_REGS(16)) bus4 ();

  regfile_write_ctrl #(.DATA_W(16), .NUM_REGS(16), .EXEC_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  regfile_write_ctrl #(.DATA_W(16), .NUM_REGS(16), .EXEC_CYCLES(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full instruction on the EXEC_CYCLES=1 instance, checked every cycle
  task automatic exec1(input string nm, input logic [15:0] ins,
                       input logic [3:0] ea, input logic [3:0] eb,
                       input logic eis, input logic [15:0] eimm,
                       input logic [7:0] eop, input logic [15:0] eregen,
                       input logic eflags);
    bus1.instr       = ins;
    bus1.instr_valid = 1'b1;
    tick();
    bus1.instr_valid = 1'b0;
    bus1.instr       = 16'hFFFF;
    chk({nm, " dec busy"},    32'(bus1.busy),        32'd1);
    chk({nm, " dec ready"},   32'(bus1.instr_ready), 32'd0);
    chk({nm, " dec srcA"},    32'(bus1.srcA_sel),    32'(ea));
    chk({nm, " dec srcB"},    32'(bus1.srcB_sel),    32'(eb));
    chk({nm, " dec imm_sel"}, 32'(bus1.imm_sel),     32'(eis));
    chk({nm, " dec imm"},     32'(bus1.imm),         32'(eimm));
    chk({nm, " dec alu_op"},  32'(bus1.alu_op),      32'(eop));
    chk({nm, " dec regEn"},   32'(bus1.regEn),       32'd0);
    chk({nm, " dec done"},    32'(bus1.done),        32'd0);
    tick();
    chk({nm, " ex done"},     32'(bus1.done),        32'd0);
    chk({nm, " ex regEn"},    32'(bus1.regEn),       32'd0);
    chk({nm, " ex srcA"},     32'(bus1.srcA_sel),    32'(ea));
    tick();
    chk({nm, " wb regEn"},    32'(bus1.regEn),       32'(eregen));
    chk({nm, " wb flags"},    32'(bus1.flags_en),    32'(eflags));
    chk({nm, " wb done"},     32'(bus1.done),        32'd1);
    chk({nm, " wb alu_op"},   32'(bus1.alu_op),      32'(eop));
    chk({nm, " wb srcB"},     32'(bus1.srcB_sel),    32'(eb));
    tick();
    chk({nm, " idle ready"},  32'(bus1.instr_ready), 32'd1);
    chk({nm, " idle done"},   32'(bus1.done),        32'd0);
    chk({nm, " idle regEn"},  32'(bus1.regEn),       32'd0);
    chk({nm, " idle flags"},  32'(bus1.flags_en),    32'd0);
    chk({nm, " idle srcA"},   32'(bus1.srcA_sel),    32'd0);
    chk({nm, " idle imm"},    32'(bus1.imm),         32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] r0_exp;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus1.instr_valid = 1'b0;
    bus1.instr       = 16'h0000;
    bus4.instr_valid = 1'b0;
    bus4.instr       = 16'h0000;

    // Reset state
    tick();
    bus1.instr_valid = 1'b1;
    bus1.instr       = 16'h0355;
    tick();
    chk("rst ready",  32'(bus1.instr_ready), 32'd1);
    chk("rst busy",   32'(bus1.busy),        32'd0);
    chk("rst regEn",  32'(bus1.regEn),       32'd0);
    chk("rst done",   32'(bus1.done),        32'd0);
    chk("rst srcA",   32'(bus1.srcA_sel),    32'd0);
    chk("rst alu_op", 32'(bus1.alu_op),      32'd0);
    bus1.instr_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("post rst busy", 32'(bus1.busy), 32'd0);

    exec1("add",  16'h0355, 4'h3, 4'h5, 1'b0, 16'h0055, 8'h05, 16'h0008, 1'b1);
    exec1("addi", 16'h58FE, 4'h8, 4'hE, 1'b1, 16'hFFFE, 8'h5F, 16'h0100, 1'b1);
    exec1("cmp",  16'h0EB2, 4'hE, 4'h2, 1'b0, 16'hFFB2, 8'h0B, 16'h0000, 1'b1);
    exec1("cmpi", 16'hB123, 4'h1, 4'h3, 1'b1, 16'h0023, 8'hB2, 16'h0000, 1'b1);
    exec1("nop",  16'h0000, 4'h0, 4'h0, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0);
`ifdef REGFILE_WRITE_CTRL_R0_PROTECT_EN
    r0_exp = 16'h0000;
`else
    r0_exp = 16'h0001;
`endif
    exec1("add_r0", 16'h0051, 4'h0, 4'h1, 1'b0, 16'h0051, 8'h05, r0_exp, 1'b1);

    // EXEC_CYCLES=4, instr_valid held across two instructions
    bus4.instr       = 16'h0355;
    bus4.instr_valid = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 1) bus4.instr = 16'h0E11;
      chk($sformatf("ex4 done c%0d", c), 32'(bus4.done),
          (c == 6 || c == 13) ? 32'd1 : 32'd0);
      chk($sformatf("ex4 regEn c%0d", c), 32'(bus4.regEn),
          (c == 6) ? 32'h0008 : (c == 13) ? 32'h4000 : 32'h0000);
      if (c == 7 || c == 14 || c == 15)
        chk($sformatf("ex4 ready c%0d", c), 32'(bus4.instr_ready), 32'd1);
      if (c == 8) begin
        chk("ex4 second srcA",   32'(bus4.srcA_sel), 32'h0E);
        chk("ex4 second srcB",   32'(bus4.srcB_sel), 32'h01);
        chk("ex4 second alu_op", 32'(bus4.alu_op),   32'h01);
        bus4.instr_valid = 1'b0;
      end
    end

    // Reset asserted during EXECUTE
    bus1.instr       = 16'h0355;
    bus1.instr_valid = 1'b1;
    tick();
    bus1.instr_valid = 1'b0;
    tick();
    chk("mid busy before", 32'(bus1.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid rst ready", 32'(bus1.instr_ready), 32'd1);
    chk("mid rst srcA",  32'(bus1.srcA_sel),    32'd0);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) reset = 1'b1;
      tick();
      chk($sformatf("mid rst done c%0d", c),  32'(bus1.done),        32'd0);
      chk($sformatf("mid rst regEn c%0d", c), 32'(bus1.regEn),       32'd0);
      chk($sformatf("mid rst ready c%0d", c), 32'(bus1.instr_ready), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_write_ctrl.md
Name: regfile_write_ctrl

Overview:
Instruction sequencer that sits directly upstream of the 16x16 register file and ALU.
- Accepts one CR16-format instruction per handshake and decodes it.
- Drives the register-read selects, the immediate and the ALU op for a programmable number of execute cycles.
- Issues the one-hot write enable (regEn) that the register file consumes to latch the ALU bus.

Parameters:
DATA_W, 16, datapath width; immediate sign-extends to this width.
NUM_REGS, 16, register count; width of regEn.
EXEC_CYCLES, 1, cycles held in EXECUTE for ALU settle; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
instr_valid  input  1  instruction present on instr
instr  input  16  {op[15:12], rdest[11:8], opext[7:4], rsrc_imm[3:0]}
instr_ready  output  1  block can accept an instruction (high only in IDLE)
busy  output  1  high in DECODE, EXECUTE and WRITEBACK
srcA_sel  output  4  read select A = rdest
srcB_sel  output  4  read select B = rsrc
imm_sel  output  1  1 = ALU B operand comes from imm
imm  output  DATA_W  sign-extended {opext, rsrc_imm}
alu_op  output  8  {op, opext}
regEn  output  NUM_REGS  one-hot register write enable
flags_en  output  1  PSR flag update strobe
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (reset=0, async): state=IDLE, all registered outputs 0, exec counter 0, instruction latch 0. instr_ready=1 (decoded from IDLE). No instruction is accepted while reset=0.
- States: IDLE -> DECODE -> EXECUTE -> WRITEBACK -> IDLE.
- IDLE: if instr_valid & instr_ready at a rising edge, latch instr and go to DECODE. Otherwise stay in IDLE.
- DECODE, one cycle:
  - Drive srcA_sel, srcB_sel, imm_sel, imm and alu_op from the latch.
  - Load the exec counter with EXEC_CYCLES-1.
- EXECUTE: hold all selects. Decrement the counter each cycle; when it is 0, go to WRITEBACK. Duration is exactly EXEC_CYCLES cycles.
- WRITEBACK, one cycle:
  - done=1 and selects are held.
  - Write strobes are set per instruction class (see below).
- Selects and imm stay stable from DECODE through WRITEBACK. They are 0 in IDLE.
- Latency: accept edge at cycle N.
  - DECODE at N+1.
  - WRITEBACK and done at N+2+EXEC_CYCLES.
  - instr_ready high again at N+3+EXEC_CYCLES.
- Throughput: one instruction per EXEC_CYCLES+3 cycles. A held instr_valid is accepted on the first IDLE cycle.
- Decode rules:
  - op=0000 is register form: imm_sel=0.
  - Any other op is immediate form: imm_sel=1, imm = sign-extension of instr[7:0].
- Compare: op=0000 with opext=1011, or op=1011 (CMPI). WRITEBACK sets flags_en=1 and regEn=0.
- NOP: instr=16'h0000. Walks all states; regEn=0, flags_en=0, done still pulses.
- All other instructions: WRITEBACK sets regEn = 1<<rdest and flags_en=1.
- regEn is 0 in every state except WRITEBACK and has at most one bit set.
- instr changes while busy are ignored; only the latched copy is used.
- Reset mid-operation (any state): immediate return to IDLE with regEn=0. No partial or late write occurs, and no done pulse.

Optional Feature:
Macro: REGFILE_WRITE_CTRL_R0_PROTECT_EN.
- Defined: any write targeting rdest=0 is suppressed. regEn=0 in WRITEBACK, while flags_en and done behave as normal.
- Undefined: r0 is an ordinary writable register (regEn=16'h0001 for rdest=0).

Test Plan:
- ADD r3,r5: instr=16'h0355, EXEC_CYCLES=1, valid pulse at cycle 0 -> DECODE at 1 with srcA_sel=3, srcB_sel=5, imm_sel=0, alu_op=8'h05. At cycle 3: regEn=16'h0008, flags_en=1, done=1, each for exactly one cycle. instr_ready=1 at cycle 4.
- ADDI r8,#-2: instr=16'h58FE -> imm_sel=1, imm=16'hFFFE, alu_op=8'h5F. In WRITEBACK: regEn=16'h0100.
- CMP r14,r2: instr=16'h0EB2 -> WRITEBACK has flags_en=1 and regEn=16'h0000. NOP 16'h0000 -> done=1, regEn=0, flags_en=0.
- EXEC_CYCLES=4 with instr_valid held high for two instructions (16'h0355 then 16'h0E11) -> done pulses at cycles 6 and 13. regEn values are 16'h0008 then 16'h4000.
- Reset pulled low during EXECUTE of 16'h0355 -> regEn stays 0, done never pulses. After release: state IDLE, instr_ready=1.
- ADD r0,r1: instr=16'h0051 -> with REGFILE_WRITE_CTRL_R0_PROTECT_EN, regEn=0 and flags_en=1. Without the macro, regEn=16'h0001.
